dco_nco: RTL

DCO_NCO -- requirements
Module: dco_nco

---
 rtl/dco_pkg.sv | 22 ++
 rtl/dco_lfsr.sv | 43 ++++
 rtl/dco_nco.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dco_pkg.sv
// -----------------------------------------------------------------------------
// dco_pkg -- shared definitions for the dco_nco numerically controlled
// oscillator.
//
// Contents:
//   dco_state_t  : oscillator control FSM states (IDLE / RUN / STOPPING)
//   LFSR_SEED    : reset value of the optional dither LFSR
//   LFSR_POLY    : Galois feedback mask of the dither LFSR
//                  (x^16 + x^14 + x^13 + x^11 + 1, maximal length)
// -----------------------------------------------------------------------------
package dco_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } dco_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

endpackage : dco_pkg

// File: rtl/dco_lfsr.sv
// -----------------------------------------------------------------------------
// dco_lfsr -- 16-bit maximal-length Galois LFSR used as a one-bit dither
// source for the dco_nco phase accumulator.
//
// Ports:
//   clk_i    in   system clock
//   reset_i  in   synchronous active-high reset, loads LFSR_SEED
//   step_i   in   advance the register by one state this cycle
//   bit_o    out  current dither bit (register LSB)
// -----------------------------------------------------------------------------
module dco_lfsr
    import dco_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic step_i,
    output logic bit_o
);

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    // Right-shifting Galois form: every bit takes its upper neighbour and is
    // flipped by the outgoing LSB wherever the polynomial has a tap.
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_shift
            assign w_lfsr_next[gi] = r_lfsr[gi+1] ^ (LFSR_POLY[gi] & r_lfsr[0]);
        end
    endgenerate
    assign w_lfsr_next[15] = LFSR_POLY[15] & r_lfsr[0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_lfsr <= LFSR_SEED;
        end else if (step_i) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign bit_o = r_lfsr[0];

endmodule : dco_lfsr

// File: rtl/dco_nco.sv
// -----------------------------------------------------------------------------
// dco_nco -- phase-accumulator oscillator with glitch-free frequency update
// and a graceful stop that never truncates a high pulse.
//
// Parameters:
//   ACC_WIDTH  phase accumulator width (must be >= FCW_WIDTH)
//   FCW_WIDTH  frequency control word width
//   FCW_RESET  active control word after reset
//
// Ports:
//   clk_i        in   system clock (single domain)
//   reset_i      in   synchronous active-high reset
//   enable_i     in   oscillator run request
//   fcw_i        in   new frequency control word
//   fcw_valid_i  in   fcw_i valid
//   fcw_ready_o  out  high when no word is pending (a new one can be taken)
//   clk_o        out  registered accumulator MSB (lags the accumulator by 1)
//   wrap_o       out  one-cycle pulse on the cycle after an accumulator wrap
//   running_o    out  high whenever the FSM is not IDLE
//
// Build option:
//   DCO_NCO_DITHER_EN  when defined, a 16-bit LFSR bit (dco_lfsr) is fed into
//                      the accumulator carry-in every RUN/STOPPING cycle.
//                      Undefined (default): exact deterministic accumulation.
// -----------------------------------------------------------------------------
module dco_nco
    import dco_pkg::*;
#(
    parameter int          ACC_WIDTH = 24,
    parameter int          FCW_WIDTH = 16,
    parameter int unsigned FCW_RESET = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [FCW_WIDTH-1:0] fcw_i,
    input  logic                 fcw_valid_i,
    output logic                 fcw_ready_o,
    output logic                 clk_o,
    output logic                 wrap_o,
    output logic                 running_o
);

    // -------------------------------------------------------------------------
    // Registers and nets
    // -------------------------------------------------------------------------
    dco_state_t             r_state;
    dco_state_t             w_state_next;

    logic [ACC_WIDTH-1:0]   r_acc;
    logic [FCW_WIDTH-1:0]   r_fcw_active;
    logic [FCW_WIDTH-1:0]   r_fcw_pend;
    logic                   r_pending;
    logic                   r_clk;
    logic                   r_wrap;

    logic                   w_active_st;   // RUN or STOPPING
    logic                   w_accept;      // handshake completes this cycle
    logic [ACC_WIDTH-1:0]   w_fcw_ext;
    logic [ACC_WIDTH:0]     w_sum;         // one extra bit holds the carry
    logic                   w_carry;
    logic                   w_wrap_now;    // accumulator wraps at this edge
    logic                   w_dither;

    // -------------------------------------------------------------------------
    // Optional dither source
    // -------------------------------------------------------------------------
`ifdef DCO_NCO_DITHER_EN
    dco_lfsr u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .step_i  (w_active_st),
        .bit_o   (w_dither)
    );
`else
    assign w_dither = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Accumulator arithmetic
    // -------------------------------------------------------------------------
    assign w_active_st = (r_state != IDLE);
    assign w_fcw_ext   = ACC_WIDTH'(r_fcw_active);
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_fcw_ext}
                       + {{ACC_WIDTH{1'b0}}, w_dither};
    assign w_carry     = w_sum[ACC_WIDTH];
    assign w_wrap_now  = w_active_st & w_carry;
    assign w_accept    = fcw_valid_i & ~r_pending;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    w_state_next = STOPPING;
                end
            end
            STOPPING: begin
                // A renewed run request wins over the terminating wrap so the
                // phase simply carries on.
                if (enable_i) begin
                    w_state_next = RUN;
                end else if (w_carry) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        running_o   = (r_state != IDLE);
        fcw_ready_o = ~r_pending;
        clk_o       = r_clk;
        wrap_o      = r_wrap;
    end

    // -------------------------------------------------------------------------
    // Phase accumulator and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc  <= '0;
            r_clk  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            // The accumulator is pinned to zero while idle and is forced to
            // zero on the wrap that ends a stop, so the next start is in phase.
            if (!w_active_st || (w_state_next == IDLE)) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
            end
            // Taking the MSB of the *current* accumulator delays clk_o by one
            // cycle; that delay lets the final high half-period of a stop
            // complete after the FSM has already returned to IDLE.
            r_clk  <= r_acc[ACC_WIDTH-1];
            r_wrap <= w_wrap_now;
        end
    end

    // -------------------------------------------------------------------------
    // Frequency control word handling
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_fcw_active <= FCW_WIDTH'(FCW_RESET);
            r_fcw_pend   <= '0;
            r_pending    <= 1'b0;
        end else if (!w_active_st) begin
            // Idle: no phase to protect, take the word immediately.
            if (w_accept) begin
                r_fcw_active <= fcw_i;
            end
            r_pending <= 1'b0;
        end else if (w_wrap_now || (r_fcw_active == '0)) begin
            // Safe switching point: the wrap boundary, or a stalled
            // accumulator (zero word) that would never reach one.
            if (w_accept) begin
                r_fcw_active <= fcw_i;
            end else if (r_pending) begin
                r_fcw_active <= r_fcw_pend;
            end
            r_pending <= 1'b0;
        end else if (w_accept) begin
            // Mid-period: park the word until the next wrap.
            r_fcw_pend <= fcw_i;
            r_pending  <= 1'b1;
        end
    end

endmodule : dco_nco
